// File: rtl/rf_wb_scoreboard_pkg.sv
// Shared widths, FIFO entry type and occupancy encoding for the
// register-file writeback scoreboard.
package rf_wb_scoreboard_pkg;
  localparam int RF_DATA_W = 16;
  localparam int RF_NREG   = 16;
  localparam int RF_NAME_W = $clog2(RF_NREG);

  typedef struct packed {
    logic [RF_NAME_W-1:0] name;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_cnt_e;

  // Slots available for enqueue this cycle, counting the entry being popped.
  function automatic logic [1:0] slots_free(fifo_cnt_e cnt, logic pop);
    return 2'd2 - 2'(cnt) + 2'(pop);
  endfunction
endpackage

// File: rtl/rf_wb_scoreboard_if.sv
// Decode-side reservation/operand-check signals plus writeback producers
// and the register-file write port of the scoreboard.
interface rf_wb_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int NAME_W = 4
);
  logic              rsv_v_i;
  logic [NAME_W-1:0] rsv_name_i;
  logic              rsv_ack_o;
  logic [NAME_W-1:0] rs_name_i;
  logic [NAME_W-1:0] rd_name_i;
  logic              rs_busy_o;
  logic              rd_busy_o;
  logic              wb_ex_v_i;
  logic [NAME_W-1:0] wb_ex_name_i;
  logic [DATA_W-1:0] wb_ex_data_i;
  logic              wb_mem_v_i;
  logic [NAME_W-1:0] wb_mem_name_i;
  logic [DATA_W-1:0] wb_mem_data_i;
  logic              wr_en_o;
  logic [NAME_W-1:0] wr_name_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              stall_o;
  logic              flush_i;
  logic              err_o;

  modport master (
    output rsv_v_i, rsv_name_i, rs_name_i, rd_name_i,
           wb_ex_v_i, wb_ex_name_i, wb_ex_data_i,
           wb_mem_v_i, wb_mem_name_i, wb_mem_data_i, flush_i,
    input  rsv_ack_o, rs_busy_o, rd_busy_o,
           wr_en_o, wr_name_o, wr_data_o, stall_o, err_o
  );

  modport slave (
    input  rsv_v_i, rsv_name_i, rs_name_i, rd_name_i,
           wb_ex_v_i, wb_ex_name_i, wb_ex_data_i,
           wb_mem_v_i, wb_mem_name_i, wb_mem_data_i, flush_i,
    output rsv_ack_o, rs_busy_o, rd_busy_o,
           wr_en_o, wr_name_o, wr_data_o, stall_o, err_o
  );
endinterface

// File: rtl/rf_wb_scoreboard_wb_fifo2.sv
// Two-entry writeback queue: up to two pushes (push0 first) and one pop per
// cycle, 1-bit wrapping pointers, occupancy held as EMPTY/ONE/FULL.
module wb_fifo2
  import rf_wb_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_clr,
  input  logic      i_push0,
  input  wb_entry_t i_d0,
  input  logic      i_push1,
  input  wb_entry_t i_d1,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output fifo_cnt_e o_cnt
);
  fifo_cnt_e r_cnt;
  fifo_cnt_e w_cnt_nxt;
  logic [1:0] w_sum;
  logic      r_rd_ptr;
  logic      r_wr_ptr;
  wb_entry_t r_mem [2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= EMPTY;
    else      r_cnt <= w_cnt_nxt;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sum     = 2'(r_cnt) + 2'(i_push0) + 2'(i_push1) - 2'(i_pop);
    if (i_clr) begin
      w_cnt_nxt = EMPTY;
    end else begin
      case (w_sum)
        2'd0:    w_cnt_nxt = EMPTY;
        2'd1:    w_cnt_nxt = ONE;
        2'd2:    w_cnt_nxt = FULL;
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else if (i_clr) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      r_rd_ptr <= r_rd_ptr ^ i_pop;
      r_wr_ptr <= r_wr_ptr ^ i_push0 ^ i_push1;
    end
  end

  // The second push lands in the slot after the first; from ONE with a pop
  // that slot is the one being vacated this cycle.
  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wr_ptr]  <= i_d0;
    if (i_push1) r_mem[!r_wr_ptr] <= i_d1;
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register reservation scoreboard arbitrating EX/MEM writebacks onto a single
// registered register-file write port, with a 2-entry overflow queue.
module rf_wb_scoreboard
  import rf_wb_scoreboard_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int NREG   = RF_NREG
) (
  input logic                clk,
  input logic                rst,
  rf_wb_scoreboard_if.slave  bus
);
  localparam int NAME_W = $clog2(NREG);

  logic [NREG-1:0]   r_rsv;
  logic              r_wr_en;
  logic [NAME_W-1:0] r_wr_name;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_err;

  fifo_cnt_e w_cnt;
  wb_entry_t w_head, w_ex, w_mem, w_sel, w_c0, w_c1;
  logic      w_stall, w_ack, w_sel_v, w_pop, w_push0, w_push1, w_err_set;
  logic [1:0] w_ncand, w_free;

  assign w_ex.name  = bus.wb_ex_name_i;
  assign w_ex.data  = bus.wb_ex_data_i;
  assign w_mem.name = bus.wb_mem_name_i;
  assign w_mem.data = bus.wb_mem_data_i;

  assign w_stall = (w_cnt == FULL);
  assign w_ack   = bus.rsv_v_i & ~r_rsv[bus.rsv_name_i] & ~w_stall & ~bus.flush_i;

  // Queue head beats EX beats MEM; whatever loses is queued in EX, MEM order.
  always_comb begin
    w_sel_v = 1'b0;
    w_sel   = w_head;
    w_pop   = 1'b0;
    w_c0    = w_ex;
    w_c1    = w_mem;
    w_ncand = 2'd0;
    if (!bus.flush_i) begin
      if (w_cnt != EMPTY) begin
        w_sel_v = 1'b1;
        w_pop   = 1'b1;
        w_ncand = 2'(bus.wb_ex_v_i) + 2'(bus.wb_mem_v_i);
        if (!bus.wb_ex_v_i) w_c0 = w_mem;
      end else if (bus.wb_ex_v_i) begin
        w_sel_v = 1'b1;
        w_sel   = w_ex;
        w_c0    = w_mem;
        w_ncand = 2'(bus.wb_mem_v_i);
      end else if (bus.wb_mem_v_i) begin
        w_sel_v = 1'b1;
        w_sel   = w_mem;
      end
    end
    w_free  = slots_free(w_cnt, w_pop);
    w_push0 = (w_ncand >= 2'd1) && (w_free >= 2'd1);
    w_push1 = (w_ncand >= 2'd2) && (w_free >= 2'd2);
  end

  assign w_err_set = ~bus.flush_i & (
      (w_stall & (bus.wb_ex_v_i | bus.wb_mem_v_i))
    | (bus.wb_ex_v_i & bus.wb_mem_v_i & (bus.wb_ex_name_i == bus.wb_mem_name_i))
    | (bus.wb_ex_v_i & ~r_rsv[bus.wb_ex_name_i])
    | (bus.wb_mem_v_i & ~r_rsv[bus.wb_mem_name_i]));

  wb_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.flush_i),
    .i_push0 (w_push0),
    .i_d0    (w_c0),
    .i_push1 (w_push1),
    .i_d1    (w_c1),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_cnt   (w_cnt)
  );

  // A same-cycle reservation of the released name wins (later assignment).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsv <= '0;
    end else if (bus.flush_i) begin
      r_rsv <= '0;
    end else begin
      if (w_sel_v) r_rsv[w_sel.name] <= 1'b0;
      if (w_ack)   r_rsv[bus.rsv_name_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_name <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= w_sel_v;
      r_err   <= r_err | w_err_set;
      if (w_sel_v) begin
        r_wr_name <= w_sel.name;
        r_wr_data <= w_sel.data;
      end
    end
  end

  assign bus.rsv_ack_o = w_ack;
  assign bus.rs_busy_o = r_rsv[bus.rs_name_i];
  assign bus.rd_busy_o = r_rsv[bus.rd_name_i];
  assign bus.wr_en_o   = r_wr_en;
  assign bus.wr_name_o = r_wr_name;
  assign bus.wr_data_o = r_wr_data;
  assign bus.stall_o   = w_stall;
  assign bus.err_o     = r_err;
endmodule

// File: doc/rf_wb_scoreboard.md
RF_WB_SCOREBOARD -- requirements
Module: rf_wb_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register data width.
REQ-002 The block SHALL have parameter NREG, default 16, meaning number of architectural registers; name width is clog2(NREG) = 4.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 rsv_v_i  in  1  ID requests reservation of destination register rsv_name_i.
REQ-006 rsv_name_i  in  4  register to reserve.
REQ-007 rsv_ack_o  out  1  reservation accepted this cycle (combinational).
REQ-008 rs_name_i, rd_name_i  in  4 each  ID source-operand names to check.
REQ-009 rs_busy_o, rd_busy_o  out  1 each  named register has a pending write (combinational).
REQ-010 wb_ex_v_i, wb_ex_name_i, wb_ex_data_i  in  1/4/DATA_W  EX writeback request.
REQ-011 wb_mem_v_i, wb_mem_name_i, wb_mem_data_i  in  1/4/DATA_W  memory-load writeback request.
REQ-012 wr_en_o, wr_name_o, wr_data_o  out  1/4/DATA_W  registered register-file write port.
REQ-013 stall_o  out  1  writeback producers SHALL NOT present requests next cycle.
REQ-014 flush_i  in  1  drop all reservations and queued writes.
REQ-015 err_o  out  1  sticky protocol-error flag.

Function
REQ-016 Scoreboard: NREG reservation bits rsv_q; rs_busy_o = rsv_q[rs_name_i], rd_busy_o = rsv_q[rd_name_i].
REQ-017 rsv_ack_o = rsv_v_i & ~rsv_q[rsv_name_i] & ~stall_o & ~flush_i; on ack the bit SHALL be set at the next edge.
REQ-018 Reserve of an already-reserved register: rsv_ack_o low, no state change.
REQ-019 Write queue: 2-entry FIFO of {name, data}, occupancy cnt_q in {0,1,2} (states EMPTY, ONE, FULL).
REQ-020 Per cycle exactly one write SHALL be selected, priority: FIFO head > EX > MEM; unselected valid requests SHALL be enqueued, EX before MEM.
REQ-021 Selected write SHALL appear on wr_*_o at the next edge (1-cycle latency); wr_en_o low when nothing selected.
REQ-022 The reservation bit of the selected name SHALL clear at the same edge wr_en_o rises.
REQ-023 Simultaneous ack-reserve and release of the same register: reserve wins, bit stays set.
REQ-024 stall_o = (cnt_q == 2), decoded from registered state only.
REQ-025 Request while stall_o high, or EX and MEM valid with equal names, or writeback to an unreserved register: err_o SHALL set; FIFO-overflow requests SHALL be dropped; other writes proceed.
REQ-026 flush_i SHALL clear rsv_q and cnt_q at the next edge, suppress wr_en_o for that cycle, and ignore same-cycle writeback inputs; err_o unaffected.
REQ-027 FIFO pointers SHALL wrap modulo 2; enqueue of 2 with dequeue of 1 in one cycle SHALL be legal from cnt_q = 1.

Reset
REQ-028 On rst low: rsv_q = 0, cnt_q = 0, FIFO pointers = 0, wr_en_o = 0, wr_name_o = 0, wr_data_o = 0, err_o = 0; stall_o therefore 0.
REQ-029 Reset asserted mid-drain SHALL discard queued writes; no write issues on the first edge after release.

Structure
REQ-030 DATA_W, NREG, register-name width and the FIFO entry struct SHALL live in the shared params include.
REQ-031 The FIFO SHALL be one sub-module, wb_fifo2 (depth 2, push0/push1/pop, count).

Verification
REQ-032 Reserve r3 -> rsv_ack_o=1; next cycle rs_name_i=3 -> rs_busy_o=1; second reserve r3 -> ack=0.
REQ-033 EX writes r3=0x00A5 alone -> next edge wr_en_o=1, wr_name_o=3, wr_data_o=0x00A5, rsv_q[3]=0.
REQ-034 EX r1=0x1111 and MEM r2=0x2222 same cycle -> r1 written cycle+1, r2 cycle+2, cnt_q 0->1->0, stall_o stays 0.
REQ-035 Two consecutive dual-writeback cycles (r1/r2 then r4/r5) -> cnt_q reaches 2, stall_o=1, writes emerge in order r1,r2,r4,r5.
REQ-036 Writeback presented while stall_o=1 -> err_o=1 and remains 1 until reset.
REQ-037 flush_i with cnt_q=2 and r6 reserved -> next cycle cnt_q=0, rs_busy_o for r6 =0, wr_en_o=0; rst low mid-drain -> all outputs 0 immediately.
